alu_sequencer: RTL
==================

# alu_sequencer

Command front-end that drives the team's 32-bit combinational `Alu` (4-bit op, operands a/b, outputs result/zero) from a valid/ready request stream and returns registered results on a valid/ready response stream. Single ALU operations complete in one execute cycle. A multiply macro-command iterates the ALU's add 32 times (shift-add). It sits between the datapath controller and the ALU instance, which is instantiated beside it in the parent.

## Interface
- `WIDTH`, 32: operand/result width; the ALU port width.
- `clk  in  1`: the only clock; all state updates on the rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `req_valid  in  1`: command present.
- `req_ready  out  1`: command can be accepted; equals (state == IDLE).
- `req_cmd  in  3`: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 XOR, 5 MUL, 6 EQ, 7 illegal.
- `req_a`, `req_b`  in  WIDTH: operands.
- `rsp_valid  out  1`: response held.
- `rsp_ready  in  1`: consumer takes the response.
- `rsp_result  out  WIDTH`: registered result.
- `rsp_zero  out  1`: registered zero flag.
- `rsp_err  out  1`: the command was illegal.
- `alu_op  out  4`: to the ALU. AND 0000, OR 0001, ADD 0010, SUB 0011, XOR 0101.
- `alu_a`, `alu_b`  out  WIDTH: to the ALU.
- `alu_result  in  WIDTH`, `alu_zero  in  1`: from the ALU, combinational.

## Operation
- FSM states:
  - IDLE: when `req_valid`, latch cmd/a/b. Go to MUL if cmd 5, RESP if cmd 7, otherwise EXEC.
  - EXEC: drive the ALU from the operand registers for one cycle. Capture into `rsp_*`, then go to RESP.
  - MUL: 32 steps controlled by a 5-bit step counter.
  - RESP: hold `rsp_valid` until `rsp_ready`, then go to IDLE.
- `alu_op` is AND (0000) in IDLE and RESP. `alu_a`/`alu_b` always show the operand registers, or the MUL registers while in MUL.
- Single operations:
  - `rsp_result` = `alu_result`, `rsp_zero` = `alu_zero`, `rsp_err` = 0.
  - ADD and SUB wrap modulo 2^WIDTH. No overflow flag.
- EQ:
  - ALU performs SUB.
  - `rsp_result` = {0…, `alu_zero`}.
  - `rsp_zero` = ~`alu_zero`, because the result is zero exactly when the operands are not equal.
- MUL:
  - Registers: acc = 0, mcand = a, mplier = b.
  - Each step: `alu_op` = ADD, `alu_a` = acc, `alu_b` = mcand.
  - acc takes `alu_result` only if mplier[0] = 1.
  - Then mcand <<= 1 and mplier >>= 1.
  - Always exactly 32 steps; no early exit.
  - `rsp_result` = low WIDTH bits of a×b. `rsp_zero` = (final acc == 0), computed locally, not from `alu_zero`.
- Illegal command (7): `rsp_result` = 0, `rsp_zero` = 1, `rsp_err` = 1. The ALU is not exercised.
- Only one command is in flight at a time. While the block is not in IDLE, `req_ready` = 0, and `req_*` is ignored.
- `rsp_*` values stay stable while `rsp_valid` = 1 and `rsp_ready` = 0.

## Timing
- Reset values (async assertion; removal is synchronous to `clk`):
  - state = IDLE, so `req_ready` = 1.
  - `rsp_valid` = 0, `rsp_result` = 0, `rsp_zero` = 0, `rsp_err` = 0.
  - `alu_op` = 0000, `alu_a` = 0, `alu_b` = 0.
  - Counter and all internal registers = 0.
- Latency is measured from the accept edge N (`req_valid` & `req_ready`):
  - single/EQ: `rsp_valid` high after edge N+1.
  - illegal: `rsp_valid` high after edge N+1.
  - MUL: `rsp_valid` high after edge N+32.
- Response handshake edge M (`rsp_valid` & `rsp_ready`): `rsp_valid` = 0 and `req_ready` = 1 after M. The earliest next accept is at edge M+1.
- Best-case throughput is one single-cycle command per 3 cycles.
- The response registers update only on the capture edge. They keep their values after the handshake until the next capture.
- `rsp_ready` asserted before `rsp_valid` has no effect.
- Reset mid-EXEC or mid-MUL aborts the command. No response is produced, and the block returns to IDLE immediately.

## Structure
- Shared package `alu_pkg` holds:
  - ALU op-code constants (AND/OR/ADD/SUB/XOR).
  - Command encodings 0–7.
  - State enum {IDLE, EXEC, MUL, RESP}.
  - `WIDTH` default.
- No sub-module. The MUL datapath (acc, mcand, mplier, counter) stays inline. The `Alu` instance lives in the parent.

## Test plan
- Reset with `req_valid` = 1 held → all outputs at reset values, no accept until `rst_n` rises, then accept on the first edge.
- ADD a=0xFFFF_FFFF, b=1 → `alu_op` 0010 in EXEC. Response 0x0000_0000, zero=1, err=0, `rsp_valid` one cycle after accept.
- EQ a=b=0x1234_5678 → result 1, zero 0. EQ a=5, b=6 → result 0, zero 1.
- MUL a=0x0001_0003, b=0x0000_0005 → 0x0005_000F after 32 cycles. MUL a=0x8000_0000, b=2 → 0, zero=1.
- cmd 7 → result 0, zero 1, err 1. Then XOR 0xF0F0_F0F0 ^ 0xFFFF_0000 → 0x0F0F_F0F0, err 0.
- Hold `rsp_ready` = 0 for 5 cycles with a new `req_valid` pending → response stable, `req_ready` = 0. Assert `rst_n` = 0 mid-MUL → `rsp_valid` never rises, IDLE on release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command front-end: ALU op-codes, command
// encodings, sequencer states and the default datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0101;

  localparam logic [4:0] MUL_LAST_STEP = 5'd31;

  typedef enum logic [2:0] {
    CMD_AND = 3'd0,
    CMD_OR  = 3'd1,
    CMD_ADD = 3'd2,
    CMD_SUB = 3'd3,
    CMD_XOR = 3'd4,
    CMD_MUL = 3'd5,
    CMD_EQ  = 3'd6,
    CMD_ILL = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MUL,
    ST_RESP
  } state_e;

endpackage

// File: rtl/alu_sequencer.sv
// Valid/ready command front-end for the external combinational ALU. Single ops
// take one execute cycle; MUL runs a 32-step shift-add through the ALU adder.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_cmd,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  state_e           r_state;
  state_e           w_state_nxt;
  cmd_e             r_cmd;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [4:0]       r_cnt;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_zero;
  logic             r_rsp_err;
  logic [WIDTH-1:0] w_acc_nxt;

  assign req_ready  = (r_state == ST_IDLE);
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_err    = r_rsp_err;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    alu_op      = ALU_AND;
    alu_a       = r_a;
    alu_b       = r_b;
    w_acc_nxt   = r_mplier[0] ? alu_result : r_acc;
    unique case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          unique case (cmd_e'(req_cmd))
            CMD_MUL: w_state_nxt = ST_MUL;
            CMD_ILL: w_state_nxt = ST_RESP;
            default: w_state_nxt = ST_EXEC;
          endcase
        end
      end
      ST_EXEC: begin
        unique case (r_cmd)
          CMD_OR:          alu_op = ALU_OR;
          CMD_ADD:         alu_op = ALU_ADD;
          CMD_SUB, CMD_EQ: alu_op = ALU_SUB;
          CMD_XOR:         alu_op = ALU_XOR;
          default:         alu_op = ALU_AND;
        endcase
        w_state_nxt = ST_RESP;
      end
      ST_MUL: begin
        alu_op = ALU_ADD;
        alu_a  = r_acc;
        alu_b  = r_mcand;
        if (r_cnt == MUL_LAST_STEP) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (r_rsp_valid && rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: all datapath registers are reset (no memories here), so the ALU
  // operand outputs read as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd        <= CMD_AND;
      r_a          <= '0;
      r_b          <= '0;
      r_acc        <= '0;
      r_mcand      <= '0;
      r_mplier     <= '0;
      r_cnt        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_cmd    <= cmd_e'(req_cmd);
            r_a      <= req_a;
            r_b      <= req_b;
            r_acc    <= '0;
            r_mcand  <= req_a;
            r_mplier <= req_b;
            r_cnt    <= '0;
          end
        end
        ST_EXEC: begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          if (r_cmd == CMD_EQ) begin
            r_rsp_result <= {{(WIDTH-1){1'b0}}, alu_zero};
            r_rsp_zero   <= ~alu_zero;
          end else begin
            r_rsp_result <= alu_result;
            r_rsp_zero   <= alu_zero;
          end
        end
        ST_MUL: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 5'd1;
          if (r_cnt == MUL_LAST_STEP) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_result <= w_acc_nxt;
            r_rsp_zero   <= (w_acc_nxt == '0);
            r_rsp_err    <= 1'b0;
          end
        end
        ST_RESP: begin
          // An illegal command enters RESP with no response yet; it is
          // captured here so rsp_valid still rises one edge after accept.
          if (!r_rsp_valid) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b1;
            r_rsp_err    <= 1'b1;
          end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
